mul_sqrt_2: RTL and testbench
=============================

# mul_sqrt_2

Multi-cycle fixed-point multiplier that scales a signed 16-bit sample by √2, the inverse of the 1/√2 twiddle scaling used in the 8-point FFT datapath. It restores magnitude on the inverse-transform / de-normalisation path and provides a golden counterpart for round-trip checks against `div_sqrt_2`. The multiply is sequential shift-add, one constant bit per cycle, behind a start/done handshake, so it uses no DSP multiplier.

## Interface
- `WIDTH`, 16: sample width, signed two's complement.
- `K`, 16'd46341 (0xB505): √2 in unsigned Q1.15.
- `FRAC`, 15: fractional bits of `K`.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `start`  in  1: request; sampled only in IDLE.
- `a`  in  WIDTH: signed operand; captured on the accepting edge.
- `busy`  out  1: high while an operation is in flight (RUN or FINISH).
- `done`  out  1: single-cycle pulse when `result`/`ovf` update.
- `result`  out  WIDTH: signed, rounded, saturated a·√2; held until the next completion.
- `ovf`  out  1: saturation occurred on the last completed operation; held with `result`.

## Operation
- States: IDLE, RUN, FINISH.
- IDLE:
  - `start`=1 → latch `a` sign-extended into the multiplicand register, clear the accumulator (WIDTH+17 bits, signed), bit counter=0, go RUN.
  - `start`=0 → stay IDLE.
- RUN, one iteration per cycle, counter i = 0..15:
  - if K[i]=1, acc += a_ext <<< i.
  - i=15 → go FINISH; otherwise i+1.
  - Exactly 16 iterations regardless of K bit pattern; no early exit.
- FINISH:
  - r = (acc + 2^(FRAC-1)) >>> FRAC, i.e. round half toward +∞.
  - r > 32767 → `result`=32767, `ovf`=1.
  - r < −32768 → `result`=−32768, `ovf`=1.
  - Otherwise `result`=r[15:0], `ovf`=0.
  - Pulse `done`, go IDLE.
- `start` while `busy`=1 is ignored; it is not queued and `a` is not re-sampled.
- Internal arithmetic must be wide enough that no intermediate wraps. Max |a·K| < 2^31, so a 33-bit signed accumulator suffices.
- Reset (any state, including mid-RUN): state=IDLE, `busy`=0, `done`=0, `result`=0, `ovf`=0, accumulator and counter cleared. An aborted operation never produces `done`.
- `rst` and `start` high on the same edge: reset wins; the request is dropped.

## Timing
- Edge E0 samples `start`=1 in IDLE.
- E1..E16 perform the 16 accumulations.
- E17 registers `result`/`ovf` and asserts `done`.
- Start-to-done latency: 17 cycles.
- `busy` is high after E0 through E17 (17 cycles) and low after E17.
- `done` is high for exactly the cycle after E17.
- Back-to-back: `start` held or re-asserted during the `done` cycle is accepted at E18, giving 18 cycles per sample.
- All outputs are registered; no combinational path from `a`/`start` to any output.

## Test plan
- Reset: assert `rst` 2 cycles with `start`=1 → all outputs 0, `busy` stays 0, no `done`.
- Basic values:
  - `a`=1000 → after 17 cycles `result`=1414 (0x0586), `ovf`=0.
  - `a`=−1000 → `result`=−1414.
  - `a`=0 → 0.
  - `a`=0xB61C (−18916) → `result`=−26751 (0x9781), `ovf`=0.
- Saturation edges:
  - `a`=23170 → 32767, `ovf`=0.
  - `a`=23171 → 32767, `ovf`=1.
  - `a`=−23170 → −32767, `ovf`=0.
  - `a`=−23171 → −32768, `ovf`=1.
  - `a`=−32768 → −32768, `ovf`=1.
- Handshake: pulse `start` with `a`=1000, then pulse `start` again at cycle 5 with `a`=2000 → single `done` at cycle 17 with 1414. `busy` exactly 17 cycles.
- Back-to-back: hold `start`=1 with `a` changing each accepted op (100, −100) → `done` at cycles 17 and 35, `result` 141 then −141.
- Reset mid-operation: `start` with `a`=1000, `rst` at cycle 8 → no `done`, `result` stays 0. A new `start` afterwards completes normally in 17 cycles.

Source files
------------

// File: rtl/mul_sqrt_2.sv
// mul_sqrt_2 -- sequential shift-add multiply of a signed sample by sqrt(2).
//
// Scales a signed WIDTH-bit sample by K = sqrt(2) in unsigned Q1.15. This
// undoes the 1/sqrt(2) twiddle scaling on the inverse-transform path. One bit
// of K is consumed per cycle, so no hardware multiplier is used. The product is
// rounded half toward +inf and saturated to the signed WIDTH-bit range.
//
// Ports:
//   clk    in   1      clock, rising edge
//   rst    in   1      synchronous active-high reset
//   start  in   1      request, sampled only while idle
//   a      in   WIDTH  signed operand, captured on the accepting edge
//   busy   out  1      operation in flight (accumulate or finish phase)
//   done   out  1      one-cycle pulse when result/ovf update
//   result out  WIDTH  signed rounded, saturated a*sqrt(2), held until next done
//   ovf    out  1      saturation flag of the last completed operation
module mul_sqrt_2 #(
  parameter int          WIDTH = 16,
  parameter logic [15:0] K     = 16'd46341,
  parameter int          FRAC  = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] a,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] result,
  output logic                    ovf
);

  // |a*K| < 2^31, plus the rounding offset, fits a 33-bit signed accumulator.
  localparam int ACC_W = WIDTH + 17;
  localparam int KBITS = 16;
  localparam int CNT_W = 4;

  localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(2 ** (FRAC - 1));
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(-(2 ** (WIDTH - 1)));

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t                   state_q;
  logic signed [ACC_W-1:0]  a_ext_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic        [CNT_W-1:0]  cnt_q;
  logic signed [WIDTH-1:0]  result_q;
  logic                     ovf_q;
  logic                     busy_q;
  logic                     done_q;

  logic signed [ACC_W-1:0]  rnd_d;
  logic signed [WIDTH-1:0]  result_d;
  logic                     ovf_d;

  // Round half toward +inf: add half an LSB, then arithmetic shift (floor).
  function automatic logic signed [ACC_W-1:0] round_q(
    input logic signed [ACC_W-1:0] acc
  );
    return (acc + HALF) >>> FRAC;
  endfunction

  function automatic logic signed [WIDTH-1:0] sat_val(
    input logic signed [ACC_W-1:0] r
  );
    if (r > MAX_V)      return MAX_V[WIDTH-1:0];
    else if (r < MIN_V) return MIN_V[WIDTH-1:0];
    else                return r[WIDTH-1:0];
  endfunction

  function automatic logic sat_flag(input logic signed [ACC_W-1:0] r);
    return (r > MAX_V) || (r < MIN_V);
  endfunction

  always_comb begin
    rnd_d    = round_q(acc_q);
    result_d = sat_val(rnd_d);
    ovf_d    = sat_flag(rnd_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_ext_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // Accept: capture operand sign-extended, clear the accumulator.
        IDLE: begin
          if (start) begin
            a_ext_q <= {{(ACC_W - WIDTH){a[WIDTH-1]}}, a};
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        // Accumulate: one constant bit per cycle, always all 16 bits.
        RUN: begin
          if (K[cnt_q]) begin
            acc_q <= acc_q + (a_ext_q <<< cnt_q);
          end
          if (cnt_q == CNT_W'(KBITS - 1)) begin
            state_q <= FINISH;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        // Finish: register rounded/saturated result and pulse done.
        FINISH: begin
          result_q <= result_d;
          ovf_q    <= ovf_d;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_mul_sqrt_2.sv
module tb_mul_sqrt_2;

  logic               clk;
  logic               rst;
  logic               start;
  logic signed [15:0] a;
  logic               busy;
  logic               done;
  logic signed [15:0] result;
  logic               ovf;

  int asserts;
  int fails;

  mul_sqrt_2 #(.WIDTH(16), .K(16'd46341), .FRAC(15)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic: exact product, round half up, saturate.
  function automatic logic signed [15:0] ref_res(input logic signed [15:0] x);
    longint p;
    longint r;
    p = longint'(x) * 46341 + 16384;
    r = p >>> 15;
    if (r > 32767)       return 16'sd32767;
    else if (r < -32768) return -16'sd32768;
    else                 return 16'(r);
  endfunction

  function automatic logic ref_ovf(input logic signed [15:0] x);
    longint p;
    longint r;
    p = longint'(x) * 46341 + 16384;
    r = p >>> 15;
    return (r > 32767) || (r < -32768);
  endfunction

  // Transaction-level model: an accepted request completes 17 edges later.
  int                 m_age;
  logic signed [15:0] m_a;
  logic               m_busy;
  logic               m_done;
  logic signed [15:0] m_result;
  logic               m_ovf;
  logic               chk_en;

  initial begin
    m_age = 0; m_a = '0; m_busy = 1'b0; m_done = 1'b0;
    m_result = '0; m_ovf = 1'b0; chk_en = 1'b0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_age = 0; m_busy = 1'b0; m_done = 1'b0;
      m_result = '0; m_ovf = 1'b0;
      chk_en = 1'b1;
    end else begin
      m_done = 1'b0;
      if (m_age == 0) begin
        if (start) begin
          m_age = 1; m_a = a; m_busy = 1'b1;
        end
      end else if (m_age == 17) begin
        m_result = ref_res(m_a);
        m_ovf    = ref_ovf(m_a);
        m_done   = 1'b1;
        m_busy   = 1'b0;
        m_age    = 0;
      end else begin
        m_age = m_age + 1;
      end
    end
  end

  task automatic check(input string nm, input longint act, input longint exp);
    asserts++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",   longint'(busy),   longint'(m_busy));
      check("done",   longint'(done),   longint'(m_done));
      check("result", longint'(result), longint'(m_result));
      check("ovf",    longint'(ovf),    longint'(m_ovf));
    end
  end

  // Single operation with hand-computed literal expectations.
  task automatic run_op(input logic signed [15:0] av, input int exp_r,
                        input int exp_o, input string nm);
    int n;
    @(negedge clk);
    start = 1'b1; a = av;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      check({nm, "_timeout"}, 1, 0);
    end else begin
      check({nm, "_latency"}, n, 17);
      check({nm, "_result"}, longint'(result), exp_r);
      check({nm, "_ovf"}, longint'(ovf), exp_o);
    end
  endtask

  initial begin
    int ndone;
    int nbusy;
    asserts = 0;
    fails   = 0;
    rst = 1'b1; start = 1'b1; a = 16'sd1234;

    // Reset with start held high: no operation may begin.
    @(negedge clk);
    @(negedge clk);
    check("rst_busy",   longint'(busy),   0);
    check("rst_done",   longint'(done),   0);
    check("rst_result", longint'(result), 0);
    check("rst_ovf",    longint'(ovf),    0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("post_rst_busy", longint'(busy), 0);

    run_op(16'sd1000,  1414,   0, "p1000");
    run_op(-16'sd1000, -1414,  0, "m1000");
    run_op(16'sd0,     0,      0, "zero");
    run_op(16'sh5B6C * -1 - 16'sd0, ref_res(-16'sd23404), ref_ovf(-16'sd23404), "m23404");
    run_op(-16'sd18916, -26751, 0, "m18916");
    run_op(16'sd23170,  32767,  0, "p23170");
    run_op(16'sd23171,  32767,  1, "p23171");
    run_op(-16'sd23170, -32767, 0, "m23170");
    run_op(-16'sd23171, -32768, 1, "m23171");
    run_op(-16'sd32768, -32768, 1, "m32768");
    run_op(16'sd32767,  32767,  1, "p32767");

    // Start while busy is ignored.
    @(negedge clk);
    start = 1'b1; a = 16'sd1000;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; nbusy = 0;
    for (int n = 0; n < 26; n++) begin
      if (n == 4) begin start = 1'b1; a = 16'sd2000; end
      if (n == 5) begin start = 1'b0; end
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        check("hs_done_cycle", n, 17);
        check("hs_result", longint'(result), 1414);
      end
      @(negedge clk);
    end
    check("hs_ndone", ndone, 1);
    check("hs_nbusy", nbusy, 17);

    // Back-to-back with start held.
    start = 1'b1; a = 16'sd100;
    @(negedge clk);
    a = -16'sd100;
    ndone = 0;
    for (int n = 0; n < 45; n++) begin
      if (n == 18) start = 1'b0;
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          check("b2b_first_cycle", n, 17);
          check("b2b_first_result", longint'(result), 141);
        end else begin
          check("b2b_second_cycle", n, 35);
          check("b2b_second_result", longint'(result), -141);
        end
      end
      @(negedge clk);
    end
    check("b2b_ndone", ndone, 2);

    // Reset mid-operation aborts without done.
    start = 1'b1; a = 16'sd1000;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 7; n++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int n = 0; n < 25; n++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("abort_ndone",  ndone, 0);
    check("abort_result", longint'(result), 0);
    check("abort_busy",   longint'(busy), 0);
    run_op(16'sd1000, 1414, 0, "after_abort");

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
